seq_barrel_shifter: RTL and testbench
=====================================

Name: seq_barrel_shifter

Overview:
- Iterative operand-2 shifter feeding the ALU's B operand and shift carry-out (shiftCout) inputs.
- Implements LSL, LSR, ASR, ROR and RRX for shift amounts 0..255, one bit per clock, with a start/busy/done handshake.
- Result and carry are held stable after done until the next accepted start, so the ALU's flag logic can sample them at any later point.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; WIDTH exists to size the counter.
- CNT_W, 6, shift-step counter width; must hold at least 33.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- D  input  32  operand to shift.
- SH_OP  input  3  0=LSL, 1=LSR, 2=ASR, 3=ROR, 4=RRX; 5..7 reserved.
- SH_AMT  input  8  shift amount (register-specified form); ignored for RRX.
- C  input  1  current carry flag, used for amount 0 and for RRX.
- F  output  32  shifted result, drives the ALU's B operand.
- shiftCout  output  1  shifter carry-out, drives the ALU's shiftCout input.
- busy  output  1  high from the cycle after start is accepted until the done cycle.
- done  output  1  one-cycle pulse; F and shiftCout are valid from this cycle onward.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; F=0, shiftCout=0, busy=0, done=0, counter=0.
  - Reset mid-operation aborts the shift; no done is produced.
- States:
  - IDLE: on start=1, latch D, SH_OP, C and the effective count n into internal registers; go to SHIFT; busy=1.
  - SHIFT: if cnt=0, assert done for one cycle, clear busy and go to IDLE. Otherwise perform one step and decrement cnt.
- Latency:
  - Start sampled at edge E0; done is high in the cycle after edge E(n+1).
  - n=0 gives 1 cycle; n=33 gives 34 cycles.
- Effective count n:
  - LSL/LSR: min(SH_AMT,33).
  - ASR: min(SH_AMT,32).
  - ROR: SH_AMT[4:0] if that is nonzero; 32 if SH_AMT!=0 and SH_AMT[4:0]=0; 0 if SH_AMT=0.
  - RRX: always 1.
- Single step (internal registers R and carry K):
  - LSL: K=R[31], R={R[30:0],0}.
  - LSR: K=R[0], R={0,R[31:1]}.
  - ASR: K=R[0], R={R[31],R[31:1]}.
  - ROR: K=R[0], R={R[0],R[31:1]}.
  - RRX: K=R[0], R={latched C,R[31:1]}.
- K is initialised to the latched C. Therefore amount 0 gives F=D and shiftCout=C.
- Boundary results that fall out of the step rules and must hold:
  - LSL 32 gives F=0, shiftCout=D[0]; LSL >32 gives F=0, shiftCout=0.
  - LSR 32 gives F=0, shiftCout=D[31]; LSR >32 gives F=0, shiftCout=0.
  - ASR >=32 gives F={32{D[31]}}, shiftCout=D[31].
  - ROR by a nonzero multiple of 32 gives F=D, shiftCout=D[31].
- F/shiftCout update:
  - F and shiftCout are the R/K registers. They change only while busy=1 and are held otherwise.
  - Intermediate values during SHIFT are not valid; consumers must wait for done.
- start while busy=1 is ignored (not queued).
- start in the same cycle as done is not accepted; it must be re-presented once busy=0.
- Reserved SH_OP (5..7): treated as n=0, so F=D and shiftCout=C after one cycle.
- rst and start asserted in the same cycle: rst wins.

Decomposition:
- Package shifter_pkg holds:
  - SH_OP codes as localparams: OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX.
  - The state encoding: ST_IDLE, ST_SHIFT.
  - The count clamp constants 32 and 33.
- Sub-module shift_step: purely combinational single-bit step taking (op, R, Cin) and returning (R_next, K_next). The FSM, counter and count-clamp logic stay in seq_barrel_shifter.

Test Plan:
1. Reset, then LSL D=32'h8000_0001 AMT=1 C=0 -> done after 2 cycles, F=32'h0000_0002, shiftCout=1; busy high in between.
2. LSR D=32'hF000_000F AMT=0 C=1 -> done after 1 cycle, F=D, shiftCout=1. Then LSR AMT=32 -> F=0, shiftCout=1. Then AMT=40 -> F=0, shiftCout=0.
3. ASR D=32'h8000_0000: AMT=4 -> F=32'hF800_0000, shiftCout=0. AMT=200 -> F=32'hFFFF_FFFF, shiftCout=1, done 33 cycles after the start edge.
4. ROR D=32'h0000_00F1: AMT=4 -> F=32'h1000_000F, shiftCout=0. AMT=64 -> F=D, shiftCout=0. RRX with C=1 -> F=32'h8000_0078, shiftCout=1.
5. Handshake: assert start again 3 cycles into a 33-step LSL -> ignored, and exactly one done pulse occurs. Start held high through done -> accepted only the cycle after busy falls.
6. Reset mid-op: assert rst 5 cycles into an ASR AMT=20 -> next cycle F=0, shiftCout=0, busy=0, and no done pulse follows.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared constants for the iterative operand-2 shifter: operation codes,
// FSM state encoding, count clamp limits and the effective-count helper.
package shifter_pkg;

  // Shift operation codes carried on SH_OP; 5..7 are reserved.
  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;

  // Controller states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Beyond these step counts the result no longer changes.
  localparam logic [7:0] CLAMP_32 = 8'd32;
  localparam logic [7:0] CLAMP_33 = 8'd33;

  // Number of single-bit steps needed for an operation and amount.
  // LSL/LSR need one extra step past 32 so the carry also drains to 0;
  // ASR saturates at 32 because further steps only replicate the sign;
  // ROR by a nonzero multiple of 32 needs a full turn so the carry
  // reflects bit 31.
  function automatic logic [7:0] eff_count(input logic [2:0] op,
                                           input logic [7:0] amt);
    logic [7:0] n;
    n = 8'd0;
    case (op)
      OP_LSL, OP_LSR: n = (amt > CLAMP_33) ? CLAMP_33 : amt;
      OP_ASR:         n = (amt > CLAMP_32) ? CLAMP_32 : amt;
      OP_ROR: begin
        if (amt[4:0] != 5'd0) n = {3'd0, amt[4:0]};
        else if (amt != 8'd0) n = CLAMP_32;
        else                  n = 8'd0;
      end
      OP_RRX:         n = 8'd1;
      default:        n = 8'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift step: given the operation, the working register and the
// latched carry-in, produce the next working register and carry.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_r,
  output logic             o_k
);

  // Select the bit that leaves the register and the bit that enters it.
  always_comb begin
    o_r = i_r;
    o_k = i_cin;
    case (i_op)
      OP_LSL: begin
        o_k = i_r[WIDTH-1];
        o_r = {i_r[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        o_k = i_r[0];
        o_r = {1'b0, i_r[WIDTH-1:1]};
      end
      OP_ASR: begin
        o_k = i_r[0];
        o_r = {i_r[WIDTH-1], i_r[WIDTH-1:1]};
      end
      OP_ROR: begin
        o_k = i_r[0];
        o_r = {i_r[0], i_r[WIDTH-1:1]};
      end
      OP_RRX: begin
        o_k = i_r[0];
        o_r = {i_cin, i_r[WIDTH-1:1]};
      end
      default: begin
        // Reserved ops never step (count is 0); hold the register.
        o_r = i_r;
        o_k = i_cin;
      end
    endcase
  end

endmodule

// File: rtl/seq_barrel_shifter.sv
// Iterative operand-2 shifter, one bit per clock. Handshake:
//   start is sampled only while busy=0. busy rises the cycle after a start
//   is accepted and stays high through the single done cycle; a start seen
//   during busy (including the done cycle) is dropped, not queued. F and
//   shiftCout are valid from the done cycle and held until the next
//   accepted start.
module seq_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       SH_OP,
  input  logic [7:0]       SH_AMT,
  input  logic             C,
  output logic [WIDTH-1:0] F,
  output logic             shiftCout,
  output logic             busy,
  output logic             done,
  output state_t           o_dbg_state
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_r;
  logic               r_k;
  logic [2:0]         r_op;
  logic               r_c;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic               w_finish;
  logic               w_busy;
  logic               w_cnt_zero;
  logic [WIDTH-1:0]   w_r_nxt;
  logic               w_k_nxt;

  assign w_cnt_zero = (r_cnt == '0);

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_op (r_op),
    .i_r  (r_r),
    .i_cin(r_c),
    .o_r  (w_r_nxt),
    .o_k  (w_k_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave IDLE on an accepted start, return when the count runs out.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && !r_done) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_cnt_zero)       w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs; the done cycle still counts as busy so a start held
  // through it is not taken until busy has visibly dropped.
  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    w_busy   = r_done;
    case (r_state)
      ST_IDLE:  w_load = start && !r_done;
      ST_SHIFT: begin
        w_busy   = 1'b1;
        w_step   = !w_cnt_zero;
        w_finish = w_cnt_zero;
      end
      default: ;
    endcase
  end

  // Datapath: latch operands on start, step until the count is exhausted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r    <= '0;
      r_k    <= 1'b0;
      r_op   <= OP_LSL;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_r   <= D;
        r_k   <= C;
        r_op  <= SH_OP;
        r_c   <= C;
        r_cnt <= CNT_W'(eff_count(SH_OP, SH_AMT));
      end else if (w_step) begin
        r_r   <= w_r_nxt;
        r_k   <= w_k_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign F           = r_r;
  assign shiftCout   = r_k;
  assign busy        = w_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Bench for seq_barrel_shifter: directed vector table, handshake and reset
// sequences, then random operations scored against a reference model.
module tb_seq_barrel_shifter;
  import shifter_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] D;
  logic [2:0]  SH_OP;
  logic [7:0]  SH_AMT;
  logic        C;
  logic [31:0] F;
  logic        shiftCout;
  logic        busy;
  logic        done;
  state_t      dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [32:0] exp_q[$];

  seq_barrel_shifter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .D          (D),
    .SH_OP      (SH_OP),
    .SH_AMT     (SH_AMT),
    .C          (C),
    .F          (F),
    .shiftCout  (shiftCout),
    .busy       (busy),
    .done       (done),
    .o_dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  amt;
    logic [31:0] d;
    logic        c;
    logic [31:0] exp_f;
    logic        exp_k;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [32:0] ref_model(input logic [2:0] op, input logic [7:0] amt,
                                            input logic [31:0] d, input logic c);
    logic [64:0]        x;
    logic signed [64:0] xs;
    logic [31:0]        f;
    logic               k;
    int                 r;
    case (op)
      3'd0: begin x = {32'd0, c, d} << amt; f = x[31:0]; k = x[32]; end
      3'd1: begin x = {32'd0, d, c} >> amt; f = x[32:1]; k = x[0]; end
      3'd2: begin xs = {{32{d[31]}}, d, c}; xs = xs >>> amt; f = xs[32:1]; k = xs[0]; end
      3'd3: begin
        r = int'(amt) % 32;
        f = (d >> r) | ((r == 0) ? 32'd0 : (d << (32 - r)));
        k = (amt == 8'd0) ? c : f[31];
      end
      3'd4: begin f = {c, d[31:1]}; k = d[0]; end
      default: begin f = d; k = c; end
    endcase
    return {k, f};
  endfunction

  // Driver: issue one operation (entered/left at posedge+1) and wait for done.
  // lat counts edges after the start edge up to the one that raises done.
  task automatic run_op(input logic [2:0] op, input logic [7:0] amt, input logic [31:0] d,
                        input logic c, output logic [31:0] f, output logic k,
                        output int lat, output int busy_lo);
    SH_OP = op; SH_AMT = amt; D = d; C = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    D = $urandom; C = 1'($urandom);
    lat = 0; busy_lo = 0;
    if (!busy) busy_lo++;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_lo++;
      if (done) break;
    end
    if (!done) lat = -1;
    f = F; k = shiftCout;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] f;
    logic        k;
    int          lat, blo, ndone, cyc;
    logic [32:0] e;

    rst = 1'b1; start = 1'b0; D = '0; SH_OP = '0; SH_AMT = '0; C = 1'b0;

    // Reset.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_F", 64'(F), 64'd0);
    chk("reset_cout", 64'(shiftCout), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    // rst wins over a simultaneous start.
    start = 1'b1; D = 32'hDEAD_BEEF; SH_AMT = 8'd5;
    @(posedge clk); #1;
    chk("rst_start_busy", 64'(busy), 64'd0);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Directed table.
    vecs.push_back('{OP_LSL, 8'd1,   32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 2});
    vecs.push_back('{OP_LSR, 8'd0,   32'hF000_000F, 1'b1, 32'hF000_000F, 1'b1, 1});
    vecs.push_back('{OP_LSR, 8'd32,  32'hF000_000F, 1'b0, 32'h0000_0000, 1'b1, 33});
    vecs.push_back('{OP_LSR, 8'd40,  32'hF000_000F, 1'b1, 32'h0000_0000, 1'b0, 34});
    vecs.push_back('{OP_ASR, 8'd4,   32'h8000_0000, 1'b0, 32'hF800_0000, 1'b0, 5});
    vecs.push_back('{OP_ASR, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 33});
    vecs.push_back('{OP_ROR, 8'd4,   32'h0000_00F1, 1'b0, 32'h1000_000F, 1'b0, 5});
    vecs.push_back('{OP_ROR, 8'd64,  32'h0000_00F1, 1'b1, 32'h0000_00F1, 1'b0, 33});
    vecs.push_back('{OP_RRX, 8'd77,  32'h0000_00F1, 1'b1, 32'h8000_0078, 1'b1, 2});
    vecs.push_back('{OP_LSL, 8'd32,  32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 33});
    vecs.push_back('{OP_LSL, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34});
    vecs.push_back('{OP_ROR, 8'd32,  32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 33});
    vecs.push_back('{3'd5,   8'd9,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1});
    vecs.push_back('{OP_LSL, 8'd0,   32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0, 1});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].amt, vecs[i].d, vecs[i].c, f, k, lat, blo);
      chk($sformatf("vec%0d_F", i), 64'(f), 64'(vecs[i].exp_f));
      chk($sformatf("vec%0d_cout", i), 64'(k), 64'(vecs[i].exp_k));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_busy", i), 64'(blo), 64'd0);
    end

    // Start during busy is ignored: exactly one done, result of the first op.
    SH_OP = OP_LSL; SH_AMT = 8'd33; D = 32'hFFFF_0000; C = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    SH_AMT = 8'd1; D = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; f = '0; k = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; f = F; k = shiftCout; end
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_F", 64'(f), 64'd0);
    chk("busy_start_cout", 64'(k), 64'd0);

    // Start held high through done is only taken once busy has dropped.
    SH_OP = OP_LSR; SH_AMT = 8'd2; D = 32'h0000_0006; C = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("held_done_seen", 64'(done), 64'd1);
    chk("held_done_busy", 64'(busy), 64'd1);
    chk("held_F", 64'(F), 64'h1);
    chk("held_cout", 64'(shiftCout), 64'd1);
    SH_AMT = 8'd4; D = 32'h0000_00F0;
    @(posedge clk); #1;
    chk("held_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("held_accept_busy", 64'(busy), 64'd1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("held2_F", 64'(F), 64'h0F);
    chk("held2_cout", 64'(shiftCout), 64'd0);
    @(posedge clk); #1;

    // Reset mid-operation aborts with no done.
    SH_OP = OP_ASR; SH_AMT = 8'd20; D = 32'h8765_4321; C = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_F", 64'(F), 64'd0);
    chk("abort_cout", 64'(shiftCout), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // Random operations scored against the model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  rop;
      logic [7:0]  ramt;
      logic [31:0] rd;
      logic        rc;
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ramt = 8'($urandom_range(0, 255));
        1:       ramt = 8'($urandom_range(30, 34));
        2:       ramt = 8'($urandom_range(0, 3));
        default: ramt = 8'(32 * $urandom_range(0, 7));
      endcase
      rd = $urandom; rc = 1'($urandom);
      exp_q.push_back(ref_model(rop, ramt, rd, rc));
      run_op(rop, ramt, rd, rc, f, k, lat, blo);
      e = exp_q.pop_front();
      if (lat < 0) chk($sformatf("rnd%0d_timeout", i), 64'(lat), 64'd0);
      else chk($sformatf("rnd%0d_op%0d_amt%0d", i, rop, ramt), 64'({k, f}), 64'(e));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
